// File: rtl/mul_iter.sv
// mul_iter: iterative RV32M multiplier (MUL, MULH, MULHSU, MULHU).
// Operands are turned into magnitudes at accept time. BITS_PER_CYCLE
// multiplier bits are retired per CALC cycle. The SIGN state applies the
// stored sign and picks the low or high product half.
//
// Parameters:
//   XLEN            operand/result width (multiple of BITS_PER_CYCLE)
//   BITS_PER_CYCLE  multiplier bits retired per cycle (1, 2, 4, 8)
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    operand handshake (in_ready = state IDLE)
//   opA, opB, op         rs1, rs2, funct3[1:0] (00 MUL, 01 MULH, 10 MULHSU, 11 MULHU)
//   flush                synchronous kill of the current operation
//   out_valid/out_ready  result handshake
//   result               selected product half, held while out_valid is high
//   busy                 high in every state except IDLE
// Build option:
//   MUL_ZERO_BYPASS_EN   a zero operand skips CALC/SIGN; the result is valid in cycle 1
module mul_iter #(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] opA,
   input  logic [XLEN-1:0] opB,
   input  logic [1:0]      op,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int ITER = XLEN / BITS_PER_CYCLE;
   localparam int CW   = $clog2(ITER + 1);

   typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

   state_t            state;
   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] mcand;    // multiplicand, pre-shifted to the current bit position
   logic [XLEN-1:0]   mplier;
   logic [CW-1:0]     cnt;
   logic [1:0]        op_q;
   logic              neg_q;

   // MUL takes the MULH signedness. Its low half is the same for every
   // signedness, so this choice does not change the MUL result.
   logic            sign_a, sign_b, neg_in;
   logic [XLEN-1:0] abs_a, abs_b;

   assign sign_a = (op != 2'b11);
   assign sign_b = ~op[1];
   assign abs_a  = (sign_a && opA[XLEN-1]) ? -opA : opA;
   assign abs_b  = (sign_b && opB[XLEN-1]) ? -opB : opB;
   assign neg_in = (sign_a & opA[XLEN-1]) ^ (sign_b & opB[XLEN-1]);

   // A digit times a multiplicand shifted by at most XLEN-BITS_PER_CYCLE
   // fits in 2*XLEN bits, so the truncated product is exact.
   logic [2*XLEN-1:0] acc_next, acc_fin;

   assign acc_next = acc + mcand * (2*XLEN)'(mplier[BITS_PER_CYCLE-1:0]);
   assign acc_fin  = neg_q ? -acc : acc;

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         cnt       <= '0;
         op_q      <= '0;
         neg_q     <= 1'b0;
         result    <= '0;
         out_valid <= 1'b0;
      end else if (flush) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         acc       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand  <= (2*XLEN)'(abs_a);
                  mplier <= abs_b;
                  acc    <= '0;
                  cnt    <= '0;
                  op_q   <= op;
                  neg_q  <= neg_in;
`ifdef MUL_ZERO_BYPASS_EN
                  if (abs_a == '0 || abs_b == '0) begin
                     state     <= DONE;
                     result    <= '0;
                     out_valid <= 1'b1;
                  end else begin
                     state <= CALC;
                  end
`else
                  state <= CALC;
`endif
               end
            end
            CALC: begin
               acc    <= acc_next;
               mcand  <= mcand << BITS_PER_CYCLE;
               mplier <= mplier >> BITS_PER_CYCLE;
               cnt    <= cnt + CW'(1);
               if (cnt == CW'(ITER - 1))
                  state <= SIGN;
            end
            SIGN: begin
               acc       <= acc_fin;
               result    <= (op_q == 2'b00) ? acc_fin[XLEN-1:0] : acc_fin[2*XLEN-1:XLEN];
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_iter.sv
// tb_mul_iter: self-checking bench for mul_iter. It uses a vector table, a
// randomized run against a 64-bit arithmetic reference, and hand-written
// sequences for backpressure, flush and reset. It also checks the latency of
// BITS_PER_CYCLE = 1 / 8 instances.
module tb_mul_iter;

   localparam int LAT = 32 / 4 + 2;
`ifdef MUL_ZERO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, in_valid, flush, out_ready;
   logic [31:0] opA, opB;
   logic [1:0]  op;
   logic        in_ready, out_valid, busy;
   logic [31:0] result;
   logic        in_ready1, out_valid1, busy1;
   logic [31:0] result1;
   logic        in_ready8, out_valid8, busy8;
   logic [31:0] result8;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   mul_iter #(.XLEN(32), .BITS_PER_CYCLE(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .opA(opA), .opB(opB), .op(op), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .busy(busy));

   mul_iter #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .opA(opA), .opB(opB), .op(op), .flush(flush), .out_valid(out_valid1),
      .out_ready(out_ready), .result(result1), .busy(busy1));

   mul_iter #(.XLEN(32), .BITS_PER_CYCLE(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
      .opA(opA), .opB(opB), .op(op), .flush(flush), .out_valid(out_valid8),
      .out_ready(out_ready), .result(result8), .busy(busy8));

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  o;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[10];

   // Reference: sign/zero-extend to 64 bits, multiply, then pick a half.
   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] o);
      logic [63:0] sa, sb, p;
      sa = (o == 2'b11) ? {32'b0, a} : {{32{a[31]}}, a};
      sb = o[1] ? {32'b0, b} : {{32{b[31]}}, b};
      p  = sa * sb;
      return (o == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input int full);
      return (BYP && (a == 0 || b == 0)) ? 1 : full;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Issue one operation (out_ready assumed high) and measure the latency.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                         output logic [31:0] res, output int lat);
      int guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
      opA = a; opB = b; op = o; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
      res = result;
      @(negedge clk);
   endtask

   // Start all three instances together, then check each latency and result.
   task automatic multi(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
      int l0 = 0, l1 = 0, l8 = 0;
      logic [31:0] r0 = '0, r1 = '0, r8 = '0;
      @(negedge clk);
      opA = a; opB = b; op = o; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         if (out_valid  && l0 == 0) begin l0 = c; r0 = result;  end
         if (out_valid1 && l1 == 0) begin l1 = c; r1 = result1; end
         if (out_valid8 && l8 == 0) begin l8 = c; r8 = result8; end
         @(negedge clk);
      end
      chk("lat bpc4", l0, exp_lat(a, b, 10));
      chk("lat bpc1", l1, exp_lat(a, b, 34));
      chk("lat bpc8", l8, exp_lat(a, b, 6));
      chk("res bpc4", r0, model(a, b, o));
      chk("res bpc1", r1, model(a, b, o));
      chk("res bpc8", r8, model(a, b, o));
      chk("idle after multi", {busy, busy1, busy8, in_ready1, in_ready8}, 5'b00011);
   endtask

   initial begin
      logic [31:0] res;
      int lat, seen, sel;
      logic [31:0] ra, rb;
      logic [1:0]  ro;

      vecs[0] = '{32'd7,        32'hFFFFFFFD, 2'b00, 32'hFFFFFFEB};
      vecs[1] = '{32'h80000000, 32'h80000000, 2'b01, 32'h40000000};
      vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 32'hFFFFFFFE};
      vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 32'hFFFFFFFF};
      vecs[4] = '{32'h12345678, 32'h00000010, 2'b00, 32'h23456780};
      vecs[5] = '{32'd3,        32'd5,        2'b00, 32'd15};
      vecs[6] = '{32'h80000000, 32'd1,        2'b01, 32'hFFFFFFFF};
      vecs[7] = '{32'h80000000, 32'd2,        2'b11, 32'd1};
      vecs[8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 32'd0};
      vecs[9] = '{32'h80000000, 32'h80000000, 2'b00, 32'd0};

      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      opA = '0; opB = '0; op = '0;
      #12;
      chk("reset out_valid", out_valid, 0);
      chk("reset result", result, 0);
      chk("reset busy", busy, 0);
      @(negedge clk); rst_n = 1'b1;
      #1 chk("in_ready after reset", in_ready, 1);

      // Directed vectors
      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].o, res, lat);
         chk($sformatf("vec%0d result", i), res, vecs[i].exp);
         chk($sformatf("vec%0d latency", i), lat, LAT);
      end

      // Zero operand
      run_op(32'd0, 32'h1234, 2'b00, res, lat);
      chk("zero result", res, 0);
      chk("zero latency", lat, exp_lat(0, 32'h1234, LAT));

      // Randomized ops against the reference
      for (int k = 0; k < 40; k++) begin
         sel = $urandom_range(0, 7);
         ra = (sel == 0) ? 32'h80000000 : (sel == 1) ? 32'hFFFFFFFF : (sel == 2) ? 32'd0 : $urandom;
         sel = $urandom_range(0, 7);
         rb = (sel == 0) ? 32'h80000000 : (sel == 1) ? 32'hFFFFFFFF : (sel == 2) ? 32'd0 : $urandom;
         ro = 2'($urandom_range(0, 3));
         run_op(ra, rb, ro, res, lat);
         chk($sformatf("rand%0d %h*%h op%0d", k, ra, rb, ro), res, model(ra, rb, ro));
         chk($sformatf("rand%0d latency", k), lat, exp_lat(ra, rb, LAT));
      end

      // Backpressure: result and in_ready held while out_ready is low
      @(negedge clk);
      out_ready = 1'b0;
      opA = 32'h12345678; opB = 32'h10; op = 2'b00; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; lat = 1;
      while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
      chk("bp latency", lat, LAT);
      for (int k = 0; k < 5; k++) begin
         chk("bp result held", result, 32'h23456780);
         chk("bp in_ready low", {in_ready, out_valid}, 2'b01);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp release", {in_ready, out_valid}, 2'b10);

      // flush together with in_valid in IDLE: no accept
      in_valid = 1'b1; flush = 1'b1; opA = 32'd9; opB = 32'd9; op = 2'b00;
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      chk("flush blocks accept", busy, 0);

      // flush in cycle 4 of a MULHU
      @(negedge clk);
      opA = 32'hFFFFFFFF; opB = 32'hFFFFFFFF; op = 2'b11; in_valid = 1'b1;
      @(negedge clk);                       // cycle 1
      in_valid = 1'b0;
      @(negedge clk);                       // cycle 2
      chk("calc busy/in_ready", {busy, in_ready}, 2'b10);
      @(negedge clk);                       // cycle 3
      @(negedge clk);                       // cycle 4
      flush = 1'b1;
      @(negedge clk);                       // cycle 5
      flush = 1'b0;
      chk("flush in_ready", in_ready, 1);
      seen = 0;
      for (int k = 0; k < 15; k++) begin
         if (out_valid) seen = 1;
         @(negedge clk);
      end
      chk("flush no out_valid", seen, 0);
      run_op(32'd3, 32'd5, 2'b00, res, lat);
      chk("post-flush result", res, 32'd15);
      chk("post-flush latency", lat, LAT);

      // Async reset in cycle 6 of a MULH
      @(negedge clk);
      opA = 32'h80000000; opB = 32'd3; op = 2'b01; in_valid = 1'b1;
      @(negedge clk);                       // cycle 1
      in_valid = 1'b0;
      repeat (5) @(negedge clk);            // cycle 6
      #1 rst_n = 1'b0;
      #1;
      chk("rst mid-op out_valid", out_valid, 0);
      chk("rst mid-op result", result, 0);
      chk("rst mid-op busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("rst release in_ready", in_ready, 1);
      run_op(32'h80000000, 32'd3, 2'b01, res, lat);
      chk("post-reset result", res, model(32'h80000000, 32'd3, 2'b01));
      chk("post-reset latency", lat, LAT);

      // Latency across BITS_PER_CYCLE = 4 / 1 / 8, all instances from reset
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      multi(32'd0, 32'h1234, 2'b00);
      multi(32'h80000000, 32'h80000000, 2'b01);
      multi(32'hDEADBEEF, 32'h00C0FFEE, 2'b10);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mul_iter.md
# mul_iter

Parametrised iterative multiplier for the RV32M execute stage. It computes MUL, MULH, MULHSU and MULHU over XLEN-bit operands, retiring BITS_PER_CYCLE multiplier bits per clock. Operands are accepted and results returned through valid/ready handshakes, so the pipeline stalls while the unit is busy. A synchronous flush kills the in-flight operation on branch mispredict or trap.

## Interface
- XLEN, 32, operand and result width; must be a multiple of BITS_PER_CYCLE.
- BITS_PER_CYCLE, 4, multiplier bits retired per CALC cycle; legal values 1, 2, 4, 8.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  unit can accept; equals (state == IDLE).
- opA  in  XLEN  rs1 operand.
- opB  in  XLEN  rs2 operand.
- op  in  2  funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- flush  in  1  synchronous kill of the current operation.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer takes the result.
- result  out  XLEN  selected product half.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, CALC, SIGN, DONE.
- ITER = XLEN / BITS_PER_CYCLE.
- IDLE: on in_valid && in_ready && !flush, capture the operands and go to CALC.
  - Capture the absolute value of opA when op is 01 or 10 and opA[XLEN-1] is set; otherwise capture opA raw.
  - Capture the absolute value of opB when op is 01 and opB[XLEN-1] is set; otherwise capture opB raw.
  - The magnitude of the most-negative value is 2^(XLEN-1), held unsigned in XLEN bits.
  - neg = (signA & opA[XLEN-1]) ^ (signB & opB[XLEN-1]). Store op and neg.
- CALC: each cycle, acc += mcand × mplier[BITS_PER_CYCLE-1:0], aligned to the current bit position; mplier shifts right by BITS_PER_CYCLE.
  - acc is 2·XLEN bits wide.
  - After ITER cycles, go to SIGN.
- SIGN: if neg, acc = ~acc + 1 (2·XLEN-bit two's complement).
  - result is loaded with acc[XLEN-1:0] for op 00, otherwise acc[2·XLEN-1:XLEN].
  - Go to DONE.
- DONE: out_valid = 1, and result is held stable. On out_ready, go to IDLE.
- MUL low half is the same for every signedness; for op 00, neg and the abs values are computed as for MULH.
- flush (any state, highest priority after reset): next state IDLE, out_valid = 0 next cycle, accumulator contents discarded.
  - flush together with in_valid in IDLE: no accept.
- Reset: state IDLE, out_valid = 0, result = 0, busy = 0, accumulator = 0.
  - in_ready reads 1 once rst_n is high.
  - Reset asserted mid-operation abandons it with no output.

## Timing
- The accept handshake happens in cycle 0.
- CALC occupies cycles 1..ITER; SIGN is cycle ITER+1.
- out_valid rises in cycle ITER+2: cycle 10 for the default configuration.
- in_ready is low from cycle 1 until the cycle after the output handshake, so there is no overlap between operations.
  - Best-case initiation interval is ITER+3.
- out_ready held low keeps the unit in DONE indefinitely; result does not change.
- out_valid and result are registered; in_ready and busy are decoded from state only, never from inputs.

## Configuration
- MUL_ZERO_BYPASS_EN defined:
  - If the captured opA or opB is zero at accept, IDLE goes straight to DONE with result = 0.
  - out_valid rises in cycle 1.
- Not defined: zero operands take the full ITER+2 latency and produce the same 0 result.

## Test plan
- MUL, opA=7, opB=0xFFFFFFFD (−3) -> result 0xFFFFFFEB, out_valid first high in cycle 10.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- Backpressure: MUL 0x12345678×0x10 with out_ready low for 5 cycles after out_valid.
  - result stays 0x23456780 throughout; in_ready stays 0.
  - in_ready returns to 1 the cycle after out_ready is raised.
- flush in cycle 4 of a MULHU -> out_valid never asserts; in_ready = 1 in cycle 5.
  - A following MUL 3×5 returns 15 with normal latency.
- rst_n pulsed low in cycle 6 of a MULH -> all outputs clear asynchronously, with out_valid = 0 and result = 0.
  - After release, the next operation completes correctly.
- MUL 0×0x1234 -> result 0, out_valid in cycle 1 with MUL_ZERO_BYPASS_EN, cycle 10 without.
  - Repeat the test with BITS_PER_CYCLE=1 (latency 34) and BITS_PER_CYCLE=8 (latency 6).
